// File: rtl/rect_fill_engine.sv
`timescale 1ns/1ps
// Rectangle fill engine: owns the video-memory write port and writes one covered cell per clock.
// Latency: first engine write appears the cycle after iStart; oDone pulses the cycle after the last write.
// Backpressure: a CPU write (iCpuWrite) takes the port with zero latency and stalls the engine for that cycle.
//
// Ports:
//   Clock, Reset                - clock, asynchronous active-high reset
//   iStart, iX0/iX1, iY0/iY1    - fill command: corners in either order, sampled only in IDLE
//   iColor                      - fill colour, latched with the command
//   iAbort                      - cancels a fill in progress (no oDone)
//   iCpuWrite/Address/Data      - CPU single-pixel write, passed straight through with priority
//   oWriteEnable/Address/DataOut- video memory write port, address is {y,x}
//   oBusy, oDone                - status: busy in FILL/DONE, one-cycle done pulse
module rect_fill_engine #(
  parameter int X_W     = 5,
  parameter int Y_W     = 5,
  parameter int COLOR_W = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [X_W-1:0]     iX0,
  input  logic [X_W-1:0]     iX1,
  input  logic [Y_W-1:0]     iY0,
  input  logic [Y_W-1:0]     iY1,
  input  logic [COLOR_W-1:0] iColor,
  input  logic               iAbort,
  input  logic               iCpuWrite,
  input  logic [X_W+Y_W-1:0] iCpuAddress,
  input  logic [COLOR_W-1:0] iCpuData,
  output logic               oWriteEnable,
  output logic [X_W+Y_W-1:0] oWriteAddress,
  output logic [COLOR_W-1:0] oDataOut,
  output logic               oBusy,
  output logic               oDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, nextState;

  logic [X_W-1:0]     xMin, xMax, curX;
  logic [Y_W-1:0]     yMin, yMax, curY;
  logic [COLOR_W-1:0] color;

  // The engine only advances on a cycle where it actually owns the port.
  logic engineWrite;
  logic lastCell;

  assign engineWrite = (state == FILL) && !iAbort && !iCpuWrite;
  // Termination compares against the latched bounds, so a full 0..max
  // fill never needs the counters to wrap.
  assign lastCell    = (curX == xMax) && (curY == yMax);

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (iStart) nextState = FILL;
      FILL: begin
        if (iAbort)                     nextState = IDLE;
        else if (!iCpuWrite && lastCell) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      xMin  <= '0;
      xMax  <= '0;
      yMin  <= '0;
      yMax  <= '0;
      curX  <= '0;
      curY  <= '0;
      color <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && iStart) begin
        xMin  <= (iX0 < iX1) ? iX0 : iX1;
        xMax  <= (iX0 < iX1) ? iX1 : iX0;
        yMin  <= (iY0 < iY1) ? iY0 : iY1;
        yMax  <= (iY0 < iY1) ? iY1 : iY0;
        curX  <= (iX0 < iX1) ? iX0 : iX1;
        curY  <= (iY0 < iY1) ? iY0 : iY1;
        color <= iColor;
      end else if (engineWrite) begin
        // Raster order: sweep x across the row, then wrap to xMin on the next row.
        // On the last cell the counters hold; they are reloaded by the next command.
        if (curX != xMax) begin
          curX <= curX + 1'b1;
        end else if (curY != yMax) begin
          curX <= xMin;
          curY <= curY + 1'b1;
        end
      end
    end
  end

  // Write-port mux: CPU first in any state (even during reset), then engine.
  always_comb begin
    oWriteEnable  = 1'b0;
    oWriteAddress = '0;
    oDataOut      = '0;
    if (iCpuWrite) begin
      oWriteEnable  = 1'b1;
      oWriteAddress = iCpuAddress;
      oDataOut      = iCpuData;
    end else if (engineWrite) begin
      oWriteEnable  = 1'b1;
      oWriteAddress = {curY, curX};
      oDataOut      = color;
    end
  end

  assign oBusy = (state != IDLE);
  assign oDone = (state == DONE);

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Hardware rectangle-fill engine between the MiniAlu execute stage and the 32×32×3-bit video memory write port. The CPU issues one fill command (two corners plus a colour), and the engine writes every covered cell, one per clock. The engine owns the video memory write port. CPU single-pixel writes (WVM) pass straight through with priority, and the engine stalls for any cycle the CPU writes. The CPU polls `oBusy` or waits for `oDone`.

## Interface
Parameters:
- `X_W`, default 5: column index width. Memory columns are 0..31.
- `Y_W`, default 5: row index width. Memory rows are 0..31.
- `COLOR_W`, default 3: pixel width, one bit each for R, G, B.

Ports:
- `Clock`, in, 1: single clock for all state.
- `Reset`, in, 1: reset is asynchronous and active-high.
- `iStart`, in, 1: command strobe. It is sampled only in IDLE.
- `iX0`, `iX1`, in, X_W: corner columns, in either order.
- `iY0`, `iY1`, in, Y_W: corner rows, in either order.
- `iColor`, in, COLOR_W: fill colour.
- `iAbort`, in, 1: cancels a fill in progress.
- `iCpuWrite`, in, 1: CPU WVM write request.
- `iCpuAddress`, in, X_W+Y_W: CPU write address in {y,x} order.
- `iCpuData`, in, COLOR_W: CPU write pixel.
- `oWriteEnable`, out, 1: to the video memory `iWriteEnable`.
- `oWriteAddress`, out, X_W+Y_W: {y,x}. This matches the VGA read address {row[8:4], col[9:5]}.
- `oDataOut`, out, COLOR_W: pixel written.
- `oBusy`, out, 1: high while in FILL or DONE.
- `oDone`, out, 1: one-cycle pulse when a fill completes normally.

## Operation
- States: IDLE, FILL, DONE. Reset and power-up state is IDLE.
- IDLE with `iStart`=1 latches the following and moves to FILL:
  - xmin/xmax = min/max(`iX0`,`iX1`)
  - ymin/ymax = min/max(`iY0`,`iY1`)
  - cur_x = xmin, cur_y = ymin
  - colour = `iColor`
- FILL, when `iCpuWrite`=0:
  - The engine writes {cur_y,cur_x} with the latched colour.
  - Then, if cur_x≠xmax: cur_x+1.
  - Else if cur_y≠ymax: cur_x=xmin, cur_y+1.
  - Else: go to DONE.
- FILL, when `iCpuWrite`=1:
  - The CPU write goes out instead.
  - cur_x, cur_y and state hold. No pixel is lost or duplicated.
- DONE: `oDone`=1 for exactly one cycle, then IDLE.
- `iAbort`=1 in FILL:
  - The engine makes no write that cycle and goes to IDLE next cycle.
  - `oDone` is not pulsed. Pixels already written stay written.
  - In IDLE or DONE, `iAbort` is ignored.
- Write-port mux, combinational:
  - `iCpuWrite`=1: pass the CPU address and data through, `oWriteEnable`=1. This applies in any state.
  - Else, in FILL with no abort: engine address and data, `oWriteEnable`=1.
  - Else: `oWriteEnable`=0, address and data 0.
- `iStart` in FILL or DONE is ignored. The command in flight and its latched values are not modified.
- A degenerate rectangle (x0=x1, y0=y1) gives exactly 1 write, then DONE.
- Counters are exact-width with no wrap. Termination compares against xmax/ymax, so a 0..31 fill never overflows.
- Number of engine writes = (xmax−xmin+1)·(ymax−ymin+1). The range is 1..1024.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state=IDLE, `oBusy`=0, `oDone`=0.
  - Counters and latched fields are 0.
  - `oWriteEnable` is 0 unless `iCpuWrite`=1.
- Reset mid-fill aborts with no `oDone`.
- `iStart` high at edge N puts state in FILL after edge N. The first engine write is presented in cycle N+1 and captured by memory at edge N+2.
- With no CPU stalls, the last write is in cycle N+W·H. `oDone` is high in cycle N+W·H+1, and `oBusy` falls in cycle N+W·H+2.
- Each CPU write cycle in FILL adds exactly one cycle to completion.
- `oBusy`, `oDone` and state are registered. Write outputs are combinational from registers plus the CPU inputs. CPU pass-through has zero latency.
- A new `iStart` is accepted the cycle `oBusy`=0 again. There is no back-to-back acceptance during DONE.

## Test plan
- Fill: reset, then start with (x0,y0)=(2,3), (x1,y1)=(3,4), colour 5. Required: writes at addresses 98, 99, 130, 131 with data 5 on consecutive cycles, then `oDone` one cycle later. `oBusy` is high for 5 cycles.
- Swapped corners: start with (3,4),(2,3). Required: an identical address sequence to the fill test.
- Collision: `iCpuWrite` pulses at address 500, data 7 during the second fill write. Required: the 500/7 write is seen, the engine sequence resumes with no skip, and `oDone` is one cycle later than in the fill test.
- Full screen: start with (0,0),(31,31). Required: 1024 writes at addresses 0..1023 in order, and `oDone` at cycle 1025 after start.
- Ignore and abort: start a 4×4 fill and assert `iStart` with different coordinates mid-fill. Required: unaffected. Restart, and assert `iAbort` after 5 writes. Required: no further writes, no `oDone`, and IDLE next cycle.
- Reset mid-fill: assert `Reset` between clock edges during FILL. Required: `oBusy`, `oWriteEnable` and `oDone` go to 0 immediately. A subsequent 1×1 start at (0,0) gives exactly one write.
